// File: rtl/mem_resp_pkg.sv
// Shared constants and helpers for the wait-state memory responder:
// access-size encodings, FSM state codes, wait-counter width and the
// misalignment rule.
package mem_resp_pkg;

    // Access size encodings; 2'b11 is treated as a word access.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Width of the wait-state down-counter (covers 0..15 wait states).
    localparam int CNT_W = 4;

    // FSM state codes.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // A word access must sit on a 4-byte boundary and a half on a 2-byte
    // boundary; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] lane, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_HALF: mis = lane[0];
            SZ_BYTE: mis = 1'b0;
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge for sized stores: replaces the addressed
// lanes of the old memory word with right-justified store data and keeps
// the remaining lanes untouched. Little-endian lane numbering.
module byte_lane_merge
    import mem_resp_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    output logic [31:0] merged_o
);

    // Select which lanes take store data according to the access size.
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (lane_i)
                    2'b00:   merged_o[7:0]   = wdata_i[7:0];
                    2'b01:   merged_o[15:8]  = wdata_i[7:0];
                    2'b10:   merged_o[23:16] = wdata_i[7:0];
                    2'b11:   merged_o[31:24] = wdata_i[7:0];
                    default: merged_o        = old_word_i;
                endcase
            end
            SZ_HALF: begin
                // lane_i[0] is never set on a committed half store.
                if (lane_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0]  = wdata_i[15:0];
                end
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wait_responder.sv
// Word-organised data memory answering CPU requests over a req/done
// handshake after a programmable number of wait states. Stores are merged
// per byte lane; loads return the whole aligned word. Misaligned accesses
// complete with err and have no side effect.
module mem_wait_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // Counter preload: the WAIT state is left when the counter reads zero,
    // so loading WAIT_CYCLES-1 yields exactly WAIT_CYCLES wait cycles.
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    // FSM and counter
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_s;

    // Latched request
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         lane_q;
    logic [1:0]         size_q;
    logic [31:0]        wdata_q;
    logic               mis_q, mis_d;

    // Registered outputs
    logic               busy_q, done_q, err_q;
    logic [31:0]        rdata_q;

    // Memory datapath
    logic [31:0]        mem_q [DEPTH_WORDS];
    logic [31:0]        old_word_s;
    logic [31:0]        merged_s;
    logic               commit_s;
    logic               mem_we_s;
    logic               rd_upd_s;

    // Address bits above the word index alias; they are intentionally ignored.
    logic               unused_addr_s;
    assign unused_addr_s = ^addr_i[31:IDX_W+2];

    // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    accept_s = 1'b1;
                    cnt_d    = WAIT_LOAD;
                    state_d  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Misalignment is decided once, at acceptance, and carried to RESP.
    always_comb begin
        if (accept_s) begin
            mis_d = is_misaligned(addr_i[1:0], size_i);
        end else begin
            mis_d = mis_q;
        end
    end

    // Side effects happen on the edge that ends RESP, and only for aligned accesses.
    always_comb begin
        commit_s = (state_q == ST_RESP);
        mem_we_s = commit_s && !mis_q && wr_q;
        rd_upd_s = commit_s && !mis_q && !wr_q;
    end

    assign old_word_s = mem_q[idx_q];

    byte_lane_merge u_merge (
        .old_word_i (old_word_s),
        .wdata_i    (wdata_q),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .merged_o   (merged_s)
    );

    // State, counter and handshake outputs; outputs are registered from next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_RESP);
            err_q   <= (state_d == ST_RESP) && mis_d;
        end
    end

    // Request latches, captured only when a request is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            lane_q  <= 2'b00;
            size_q  <= SZ_WORD;
            wdata_q <= 32'h0000_0000;
            mis_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_q    <= wr_i;
                idx_q   <= addr_i[IDX_W+1:2];
                lane_q  <= addr_i[1:0];
                size_q  <= size_i;
                wdata_q <= wdata_i;
            end
            mis_q <= mis_d;
        end
    end

    // Load result register; holds until the next successful load completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'h0000_0000;
        end else if (rd_upd_s) begin
            rdata_q <= old_word_s;
        end
    end

    // Memory array write port; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= merged_s;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: doc/mem_wait_responder.md
# mem_wait_responder

Word-organised data memory that answers the multicycle CPU's memory requests over a req/done handshake with a programmable number of wait states, replacing the fixed-latency memory path. It performs sized stores (byte, half, word) internally by byte-lane merge and returns the full aligned word on reads, leaving extraction to the CPU's load-size logic. It also flags misaligned accesses to the control FSM.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two.
- WAIT_CYCLES, 2, wait states between request acceptance and response; 0..15.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only while busy=0.
- wr  in  1  1 = store, 0 = load; sampled with req.
- addr  in  32  byte address; sampled with req.
- size  in  2  00 word, 01 half, 10 byte; 11 treated as word.
- wdata  in  32  store data, right-justified for half/byte; sampled with req.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid only with done.
- rdata  out  32  aligned word read; held until the next successful load completes.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if req=1, latch wr/addr/size/wdata and compute misalignment. Misaligned means word with addr[1:0]≠0, or half with addr[0]=1. Go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0), loading wait counter with WAIT_CYCLES-1.
- WAIT: decrement counter; at 0 go to RESP. req ignored.
- RESP: done=1 and err=misaligned; return to IDLE.
  - If not misaligned and wr=1: write merged word at the end of RESP.
  - If not misaligned and wr=0: update rdata at the end of RESP, so it is visible the cycle after done.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (wrap modulo DEPTH_WORDS×4).
- Byte order is little-endian: byte at addr[1:0]=0 is bits 7:0.
- Byte store replaces lane addr[1:0] with wdata[7:0]. Half store replaces lanes {1,0} (addr[1]=0) or {3,2} (addr[1]=1) with wdata[15:0]. Other lanes are preserved.
- Misaligned access: no write, rdata unchanged, err=1 with done.
- Memory array is not reset; contents are undefined until written, or initialised by the bench.

## Timing
- Reset values: state IDLE, busy=0, done=0, err=0, rdata=0, counter=0.
- Latency: req sampled high at edge N gives done high during cycle N+WAIT_CYCLES+1.
- With WAIT_CYCLES=0, done is high in the cycle immediately after acceptance.
- busy rises in the cycle after acceptance and falls together with done.
- A new req may be accepted in the cycle after done, so back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- req held high continuously is accepted again as soon as IDLE is re-entered; no edge detection.
- Reset asserted mid-operation aborts the access, and no memory write occurs because writes happen only on the RESP edge. An access reset exactly on the RESP edge is not written.
- Read-after-write to the same word in consecutive accesses returns the new data.

## Structure
- Shared package mem_resp_pkg holds:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - state enum {IDLE, WAIT, RESP};
  - WAIT counter width constant (4).
- One combinational sub-module, byte_lane_merge: inputs old word, wdata, addr[1:0], size; output merged word.
- FSM, counter, latches and array live in the top.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 (WAIT_CYCLES=2) -> done 3 cycles after each req, rdata=0xDEADBEEF, err=0.
- Byte store 0xAA to 0x11 over word 0x11223344 at 0x10 -> reload gives 0x1122AA44. Half store 0x5566 to 0x12 -> 0x5566AA44.
- Half store to 0x13 and word load from 0x22 -> done with err=1, memory word at 0x10 unchanged, rdata unchanged.
- req pulsed while busy=1 -> ignored, exactly one done per accepted request. With WAIT_CYCLES=0 -> done one cycle after req.
- Reset asserted during WAIT of a word store 0x12345678 to 0x20 (prior content 0x0) -> busy/done/rdata return to 0; reload of 0x20 returns 0x0.
- Address 0x400 with DEPTH_WORDS=256 -> aliases word 0. Store 0xCAFEF00D to 0x400, load 0x0 -> 0xCAFEF00D.
